data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set word-address width; array depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SHALL set data word width.
REQ-003 Parameter TAG_W, default 5, SHALL set width of the destination-register tag echoed with read data.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be synchronous and active-high.
REQ-006 req_valid  in  1  SHALL flag a memory request from the M1 stage.
REQ-007 req_ready  out  1  SHALL flag that the responder accepts a request this cycle.
REQ-008 req_write  in  1  SHALL select a store (1) or a load (0).
REQ-009 req_addr  in  ADDR_W  SHALL carry the word address.
REQ-010 req_wdata  in  DATA_W  SHALL carry the store data.
REQ-011 req_tag  in  TAG_W  SHALL carry the load destination register.
REQ-012 rsp_valid  out  1  SHALL flag a valid load response.
REQ-013 rsp_ready  in  1  SHALL flag that the consumer takes the response this cycle.
REQ-014 rsp_rdata  out  DATA_W  SHALL carry the load data.
REQ-015 rsp_tag  out  TAG_W  SHALL carry the tag of the load being answered.
REQ-016 init_busy  out  1  SHALL be high while the clear sweep runs.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high.
REQ-018 An accepted store SHALL write req_wdata to req_addr at the acceptance edge and SHALL produce no response.
REQ-019 An accepted load SHALL read req_addr at the acceptance edge and push {data, tag} into a 2-entry response FIFO at that edge.
REQ-020 rsp_valid SHALL be high in the cycle after the acceptance edge when the FIFO was empty (1-cycle load latency).
REQ-021 rsp_rdata/rsp_tag SHALL show the FIFO head and hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022 The head SHALL pop on a rising edge where rsp_valid and rsp_ready are both high.
REQ-023 Responses SHALL leave in acceptance order.
REQ-024 req_ready SHALL equal (state==SERVE) and (fifo_count<2 or rsp_ready); it SHALL gate loads and stores alike.
REQ-025 Simultaneous push and pop with fifo_count=2 SHALL leave count at 2 with no loss.
REQ-026 Simultaneous push and pop with fifo_count=1 SHALL leave count at 1, with the new entry at the head after the pop.
REQ-027 A load issued after a store to the same address SHALL return the stored value.
REQ-028 Back-to-back loads SHALL sustain one per cycle while rsp_ready=1.
REQ-029 FSM states SHALL be INIT and SERVE.
REQ-030 INIT SHALL step a 2**ADDR_W counter from 0 and write zero to one word per cycle.
REQ-031 INIT SHALL go to SERVE after the final address; init_busy=1 and req_ready=0 throughout INIT.
REQ-032 SERVE SHALL be held until reset.

Reset
REQ-033 While reset is high, rsp_valid SHALL be 0, rsp_rdata 0, rsp_tag 0, and req_ready 0.
REQ-034 While reset is high, fifo_count and the pointers SHALL be 0, the init counter 0, and state INIT.
REQ-035 With DATA_MEM_CLEAR_EN, init_busy SHALL be 1 while reset is high.
REQ-036 Reset mid-operation SHALL flush pending responses without delivering them.
REQ-037 Reset mid-operation SHALL abort any clear sweep and restart it from address 0.

Configuration
REQ-038 Macro DATA_MEM_CLEAR_EN defined: the INIT sweep of REQ-030/031 SHALL run; after reset release, req_ready SHALL rise after 2**ADDR_W cycles and every word SHALL read 0.
REQ-039 DATA_MEM_CLEAR_EN undefined: INIT SHALL last exactly one cycle, init_busy SHALL tie to 0, and array contents SHALL not be modified by reset.

Verification
REQ-040 Clear: with DATA_MEM_CLEAR_EN, release reset -> init_busy high 128 cycles, then req_ready=1; a load of addr 0x7F returns 0x00000000.
REQ-041 Store/load: store 0xDEADBEEF to 0x05, then load 0x05 with tag 3 on the next cycle -> next cycle rsp_valid=1, rdata 0xDEADBEEF, tag 3.
REQ-042 Backpressure: rsp_ready=0, issue 3 loads -> first two accepted, req_ready=0 for the third; raise rsp_ready -> all three return in order with correct tags.
REQ-043 Full push+pop: fifo_count=2, rsp_ready=1, new load presented -> accepted the same cycle; no response lost or duplicated.
REQ-044 Reset mid-stream: two responses pending, assert reset for 1 cycle -> rsp_valid=0 next cycle, and neither pending response appears after reset.
REQ-045 Streaming: 64 consecutive loads of 0x00-0x3F after matching stores, rsp_ready=1 -> 64 responses on 64 consecutive cycles with matching data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a 2-entry load-response FIFO and tag echo.
// Define DATA_MEM_CLEAR_EN to zero the whole array after every reset.
module data_mem_responder #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              init_busy
);

  typedef enum logic {INIT, SERVE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] fifo_data [2];
  logic [TAG_W-1:0]  fifo_tag [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_count;
  logic              push;
  logic              pop;
  logic              store;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
`ifdef DATA_MEM_CLEAR_EN
  logic [ADDR_W-1:0] init_cnt;
`endif

  // A full FIFO can still take a load when the head leaves on the same edge.
  assign req_ready = !reset && (state == SERVE) && ((fifo_count < 2'd2) || rsp_ready);
  assign rsp_valid = !reset && (fifo_count != 2'd0);
  assign rsp_rdata = reset ? '0 : fifo_data[rd_ptr];
  assign rsp_tag   = reset ? '0 : fifo_tag[rd_ptr];
  assign push      = req_valid && req_ready && !req_write;
  assign store     = req_valid && req_ready && req_write;
  assign pop       = rsp_valid && rsp_ready;

`ifdef DATA_MEM_CLEAR_EN
  assign init_busy = reset || (state == INIT);
`else
  assign init_busy = 1'b0;
`endif

  always_comb begin
    mem_we    = store;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
`ifdef DATA_MEM_CLEAR_EN
    if (!reset && (state == INIT)) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INIT;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
      end
`ifdef DATA_MEM_CLEAR_EN
      init_cnt   <= '0;
`endif
    end else begin
      case (state)
        INIT: begin
`ifdef DATA_MEM_CLEAR_EN
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {ADDR_W{1'b1}}) begin
            state <= SERVE;
          end
`else
          state <= SERVE;
`endif
        end
        default: state <= SERVE;
      endcase

      if (push) begin
        fifo_data[wr_ptr] <= mem[req_addr];
        fifo_tag[wr_ptr]  <= req_tag;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: random and directed traffic checked
// against an array/queue reference model; honours DATA_MEM_CLEAR_EN.
module tb_data_mem_responder;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 2**ADDR_W;
`ifdef DATA_MEM_CLEAR_EN
  localparam int  INIT_CYCLES = DEPTH;
  localparam bit  CLEAR_EN    = 1'b1;
`else
  localparam int  INIT_CYCLES = 1;
  localparam bit  CLEAR_EN    = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic [TAG_W-1:0]  rsp_tag;
  logic              init_busy;

  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                written [DEPTH];
  rsp_t              exp_q [$];
  int                init_left = 0;
  int                checks_total = 0;
  int                checks_passed = 0;

  data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_tag(rsp_tag), .init_busy(init_busy)
  );

  always #5 clock = ~clock;

  function automatic void checkOutput(input string name, input logic [63:0] actual,
                                      input logic [63:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    else
      checks_passed++;
  endfunction

  // One clock cycle: drive at +1, check handshake at +2, update the model at +4.
  task automatic applyStimulus(input bit rst, input bit v, input bit w,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [TAG_W-1:0] t, input bit rr, output bit acc);
    bit exp_ready;
    @(posedge clock);
    #1;
    reset = rst; req_valid = v; req_write = w; req_addr = a;
    req_wdata = d; req_tag = t; rsp_ready = rr;
    #1;
    exp_ready = !rst && (init_left == 0) && ((exp_q.size() < 2) || rr);
    checkOutput("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
    checkOutput("init_busy", {63'd0, init_busy}, {63'd0, CLEAR_EN && (rst || init_left > 0)});
    acc = v && exp_ready;
    #2;
    if (rst) begin
      exp_q.delete();
      init_left = INIT_CYCLES;
      if (CLEAR_EN) begin
        for (int i = 0; i < DEPTH; i++) begin
          model_mem[i] = '0;
          written[i]   = 1'b1;
        end
      end
    end else begin
      if (init_left > 0) init_left--;
      if (acc && w) begin
        model_mem[a] = d;
        written[a]   = 1'b1;
      end else if (acc) begin
        exp_q.push_back('{data: model_mem[a], tag: t});
      end
    end
  endtask

  task automatic idle(input int n, input bit rr);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, rr, acc);
  endtask

  task automatic doReset(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
    for (int i = 0; i < INIT_CYCLES + 4 && init_left > 0; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
  endtask

  task automatic issue(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [TAG_W-1:0] t, input bit rr);
    bit acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) applyStimulus(1'b0, 1'b1, w, a, d, t, rr, acc);
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: compares the presented head against the oldest expected response.
  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (reset) begin
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("rst_rsp_tag", {59'd0, rsp_tag}, 64'd0);
      end else if (exp_q.size() == 0) begin
        checkOutput("rsp_valid_idle", {63'd0, rsp_valid}, 64'd0);
      end else begin
        checkOutput("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_q[0].data});
        checkOutput("rsp_tag", {59'd0, rsp_tag}, {59'd0, exp_q[0].tag});
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit acc;
    bit w;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      written[i]   = 1'b0;
    end

    doReset(3);
    idle(1, 1'b1);

    if (CLEAR_EN) begin
      issue(1'b0, 7'h7F, '0, 5'd1, 1'b1);
      idle(2, 1'b1);
    end

    issue(1'b1, 7'h05, 32'hDEADBEEF, '0, 1'b1);
    issue(1'b0, 7'h05, '0, 5'd3, 1'b1);
    idle(2, 1'b1);

    // Backpressure: two loads fill the FIFO, the third waits for rsp_ready.
    issue(1'b1, 7'h10, 32'h1111_0010, '0, 1'b1);
    issue(1'b1, 7'h11, 32'h2222_0011, '0, 1'b1);
    issue(1'b1, 7'h12, 32'h3333_0012, '0, 1'b1);
    issue(1'b0, 7'h10, '0, 5'd7, 1'b0);
    issue(1'b0, 7'h11, '0, 5'd8, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 7'h12, '0, 5'd9, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 1'b0, 7'h12, '0, 5'd9, 1'b0, acc);
    issue(1'b0, 7'h12, '0, 5'd9, 1'b1);
    idle(4, 1'b1);

    // Two responses pending, then a one-cycle reset must discard them.
    issue(1'b0, 7'h10, '0, 5'd12, 1'b0);
    issue(1'b0, 7'h11, '0, 5'd13, 1'b0);
    doReset(1);
    idle(3, 1'b1);

    // Streaming: 64 stores then 64 back-to-back loads.
    for (int i = 0; i < 64; i++) issue(1'b1, 7'(i), $urandom, '0, 1'b1);
    for (int i = 0; i < 64; i++) issue(1'b0, 7'(i), '0, 5'(i), 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 2) == 0);
      a = 7'($urandom_range(0, DEPTH - 1));
      if (!written[a]) w = 1'b1;
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), w, a, $urandom,
                    5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), acc);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
